// File: rtl/pattern_gen.sv
// pattern_gen: prescaled LED/IO pattern generator feeding the I2C write path.
// Each new word is offered through a valid/ready handshake; steps that would
// overwrite an unaccepted word are dropped and flagged via the sticky overrun.
module pattern_gen #(
    parameter int                 WIDTH    = 16,
    parameter int                 TICK_DIV = 50000,
    parameter logic [WIDTH-1:0]   INIT     = WIDTH'(16'h00FF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] wdata,
    output logic             wvalid,
    input  logic             wready,
    output logic             overrun
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [CNT_W-1:0] count;
    dir_t             dir;
    dir_t             next_dir;
    logic [WIDTH-1:0] next_word;
    mode_t            cur_mode;
    logic             tick;
    logic             accept;
    logic             step;
    logic             drop;

    // Tick qualification: a step is taken only when the output slot is free
    // or being emptied this cycle; otherwise the tick is dropped. Load
    // preempts the tick entirely, so it neither steps nor counts as a drop.
    always_comb begin
        cur_mode = mode_t'(mode);
        tick     = en && (count == LAST);
        accept   = wvalid && wready;
        step     = tick && !load && (!wvalid || wready);
        drop     = tick && !load && wvalid && !wready;
    end

    // Next pattern word and bounce direction for the current mode.
    always_comb begin
        next_word = wdata;
        next_dir  = dir;
        case (cur_mode)
            MODE_ROL:    next_word = {wdata[WIDTH-2:0], wdata[WIDTH-1]};
            MODE_ROR:    next_word = {wdata[0], wdata[WIDTH-1:1]};
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    if (wdata[WIDTH-1]) begin
                        next_dir  = DIR_RIGHT;
                        next_word = {wdata[0], wdata[WIDTH-1:1]};
                    end else begin
                        next_word = {wdata[WIDTH-2:0], wdata[WIDTH-1]};
                    end
                end else begin
                    if (wdata[0]) begin
                        next_dir  = DIR_LEFT;
                        next_word = {wdata[WIDTH-2:0], wdata[WIDTH-1]};
                    end else begin
                        next_word = {wdata[0], wdata[WIDTH-1:1]};
                    end
                end
            end
            MODE_COUNT:  next_word = wdata + WIDTH'(1);
        endcase
    end

    // Prescaler: restarts on load, holds while disabled, wraps at TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Bounce direction: only meaningful in bounce mode, otherwise held left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= DIR_LEFT;
        end else if (load || cur_mode != MODE_BOUNCE) begin
            dir <= DIR_LEFT;
        end else if (step) begin
            dir <= next_dir;
        end
    end

    // Output word and valid flag; INIT is offered as the first word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata  <= INIT;
            wvalid <= 1'b1;
        end else if (load) begin
            wdata  <= load_data;
            wvalid <= 1'b1;
        end else if (step) begin
            wdata  <= next_word;
            wvalid <= 1'b1;
        end else if (accept) begin
            wvalid <= 1'b0;
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed self-checking bench for pattern_gen (TICK_DIV = 4).
module tb_pattern_gen;

    localparam int WIDTH    = 16;
    localparam int TICK_DIV = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             clr_overrun;
    logic [WIDTH-1:0] wdata;
    logic             wvalid;
    logic             wready;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    pattern_gen #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV),
        .INIT     (16'h00FF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .load_data   (load_data),
        .clr_overrun (clr_overrun),
        .wdata       (wdata),
        .wvalid      (wvalid),
        .wready      (wready),
        .overrun     (overrun)
    );

    // 10-unit clock; outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    // Wait for the next presented word and check its value and spacing.
    task automatic get_word(input logic [15:0] expected, input int gap, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wvalid && n < 20);
        checks++;
        if (wvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s: wvalid=%b after %0d cycles, required 1", name, wvalid, n);
        end else begin
            checks++;
            if (wdata !== expected) begin
                failures++;
                $display("[TB] FAIL %s: wdata=%h, required %h", name, wdata, expected);
            end
            if (gap > 0) begin
                checks++;
                if (n !== gap) begin
                    failures++;
                    $display("[TB] FAIL %s spacing: %0d cycles, required %0d", name, n, gap);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        en          = 1'b1;
        mode        = 2'b00;
        load        = 1'b0;
        load_data   = '0;
        clr_overrun = 1'b0;
        wready      = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wdata !== 16'h00FF) begin
            failures++;
            $display("[TB] FAIL reset wdata: %h, required 00ff", wdata);
        end
        checks++;
        if (wvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset wvalid: %b, required 1", wvalid);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset overrun: %b, required 0", overrun);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rotate_left();
        logic [15:0] exp_word;
        wready = 1'b1;
        mode   = 2'b00;
        get_word(16'h01FE, 4, "rol1");
        get_word(16'h03FC, 4, "rol2");
        get_word(16'h07F8, 4, "rol3");
        exp_word = 16'h07F8;
        for (int i = 4; i <= 16; i++) begin
            exp_word = {exp_word[14:0], exp_word[15]};
            get_word(exp_word, 4, $sformatf("rol%0d", i));
        end
        checks++;
        if (wdata !== 16'h00FF) begin
            failures++;
            $display("[TB] FAIL rol wrap: wdata=%h, required 00ff", wdata);
        end
    endtask

    task automatic test_bounce();
        logic [15:0] seq [17];
        seq = '{16'h01FE, 16'h03FC, 16'h07F8, 16'h0FF0, 16'h1FE0, 16'h3FC0,
                16'h7F80, 16'hFF00, 16'h7F80, 16'h3FC0, 16'h1FE0, 16'h0FF0,
                16'h07F8, 16'h03FC, 16'h01FE, 16'h00FF, 16'h01FE};
        mode = 2'b10;
        for (int i = 0; i < 17; i++) begin
            get_word(seq[i], 4, $sformatf("bounce%0d", i));
        end
    endtask

    task automatic test_count_wrap();
        mode      = 2'b11;
        load      = 1'b1;
        load_data = 16'hFFFE;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (wvalid !== 1'b1 || wdata !== 16'hFFFE) begin
            failures++;
            $display("[TB] FAIL count load: wvalid=%b wdata=%h, required 1 fffe", wvalid, wdata);
        end
        get_word(16'hFFFF, 4, "count1");
        get_word(16'h0000, 4, "count2");
        get_word(16'h0001, 4, "count3");
    endtask

    task automatic test_back_to_back();
        wready = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun before drops: %b, required 0", overrun);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (wdata !== 16'h0001 || wvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure hold: wvalid=%b wdata=%h, required 1 0001", wvalid, wdata);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overrun set: %b, required 1", overrun);
        end
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        checks++;
        if (wvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL accept clears wvalid: %b, required 0", wvalid);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_overrun: %b, required 0", overrun);
        end
        wready = 1'b1;
        get_word(16'h0002, 2, "after_drop");
    endtask

    task automatic test_load_vs_tick();
        mode = 2'b00;
        repeat (3) @(negedge clk);
        load      = 1'b1;
        load_data = 16'hA5A5;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (wvalid !== 1'b1 || wdata !== 16'hA5A5) begin
            failures++;
            $display("[TB] FAIL load on tick: wvalid=%b wdata=%h, required 1 a5a5", wvalid, wdata);
        end
        get_word(16'h4B4B, 4, "after_load");
    endtask

    task automatic test_enable();
        int stray = 0;
        @(negedge clk);
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wvalid !== 1'b0 || wdata !== 16'h4B4B) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("[TB] FAIL en hold: %0d cycles with a step, required 0", stray);
        end
        en = 1'b1;
        get_word(16'h9696, 3, "en_resume");
    endtask

    task automatic test_mid_reset();
        wready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (overrun !== 1'b1 || wdata !== 16'h9696) begin
            failures++;
            $display("[TB] FAIL pre-reset drop: overrun=%b wdata=%h, required 1 9696", overrun, wdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wdata !== 16'h00FF || wvalid !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async reset: wdata=%h wvalid=%b overrun=%b, required 00ff 1 0",
                     wdata, wvalid, overrun);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wdata !== 16'h00FF || wvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post-reset hold: wdata=%h wvalid=%b, required 00ff 1", wdata, wvalid);
        end
    endtask

    // Scenario sequence; each task leaves the bench on a falling edge.
    initial begin
        test_reset();
        test_rotate_left();
        test_bounce();
        test_count_wrap();
        test_back_to_back();
        test_load_vs_tick();
        test_enable();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
